// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes,
// responder FSM encoding and the TRUE/FALSE constants used by the core.
package mem_defs;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_align.sv
// Byte-lane steering for the data memory: store lane enables and data
// placement, load extraction and extension, and access legality flags.
module mem_align
  import mem_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] rdata_shift_s;

  // Move store data up to its lane and bring the addressed load lane down to bit 0
  always_comb begin
    wdata_shifted = wdata << {addr_lo, 3'b000};
    rdata_shift_s = rdata_raw >> {addr_lo, 3'b000};
  end

  // Decode access width into lane enables, extension and legality
  always_comb begin
    byte_en   = 4'b0000;
    rdata_ext = 32'h0000_0000;
    misalign  = FALSE;
    illegal   = FALSE;
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        rdata_ext = {{24{rdata_shift_s[7]}}, rdata_shift_s[7:0]};
      end
      F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        rdata_ext = {24'h00_0000, rdata_shift_s[7:0]};
        illegal   = write;
      end
      F3_H: begin
        byte_en   = 4'b0011 << addr_lo;
        rdata_ext = {{16{rdata_shift_s[15]}}, rdata_shift_s[15:0]};
        misalign  = addr_lo[0];
      end
      F3_HU: begin
        byte_en   = 4'b0011 << addr_lo;
        rdata_ext = {16'h0000, rdata_shift_s[15:0]};
        misalign  = addr_lo[0];
        illegal   = write;
      end
      F3_W: begin
        byte_en   = 4'b1111;
        rdata_ext = rdata_raw;
        misalign  = (addr_lo != 2'b00);
      end
      default: begin
        illegal = TRUE;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I MEM stage: valid/ready request and
// response channels, programmable access latency, little-endian byte array.
module dmem_responder
  import mem_defs::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [7:0]            dbg_byte
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  // Counter preload; the access happens on the edge it would step to zero
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  dmem_state_e state_r;
  logic [3:0]  cnt_r;
  logic        hold_write_r;
  logic [2:0]  hold_funct3_r;
  logic [31:0] hold_addr_r;
  logic [31:0] hold_wdata_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_error_r;
  logic [7:0]  mem_r [DEPTH];

  logic                  acc_write_s;
  logic [2:0]            acc_funct3_s;
  logic [31:0]           acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic [ADDR_WIDTH-3:0] word_idx_s;
  logic [31:0]           rdata_raw_s;
  logic [3:0]            byte_en_s;
  logic [31:0]           wdata_shifted_s;
  logic [31:0]           rdata_ext_s;
  logic                  misalign_s;
  logic                  illegal_s;
  logic                  oor_s;
  logic                  error_s;
  logic                  enter_resp_s;
  logic                  commit_s;
  logic [31:0]           load_data_s;

  // With a one-cycle latency the access uses the live request, otherwise the held copy
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_write_s  = req_write;
      acc_funct3_s = req_funct3;
      acc_addr_s   = req_addr;
      acc_wdata_s  = req_wdata;
    end else begin
      acc_write_s  = hold_write_r;
      acc_funct3_s = hold_funct3_r;
      acc_addr_s   = hold_addr_r;
      acc_wdata_s  = hold_wdata_r;
    end
  end

  assign word_idx_s  = acc_addr_s[ADDR_WIDTH-1:2];
  assign rdata_raw_s = {mem_r[{word_idx_s, 2'd3}], mem_r[{word_idx_s, 2'd2}],
                        mem_r[{word_idx_s, 2'd1}], mem_r[{word_idx_s, 2'd0}]};
  assign oor_s       = |acc_addr_s[31:ADDR_WIDTH];

  mem_align u_align (
    .funct3        (acc_funct3_s),
    .addr_lo       (acc_addr_s[1:0]),
    .write         (acc_write_s),
    .wdata         (acc_wdata_s),
    .rdata_raw     (rdata_raw_s),
    .byte_en       (byte_en_s),
    .wdata_shifted (wdata_shifted_s),
    .rdata_ext     (rdata_ext_s),
    .misalign      (misalign_s),
    .illegal       (illegal_s)
  );

  // Identify the edge that performs the access and raises the response
  always_comb begin
    enter_resp_s = FALSE;
    case (state_r)
      ST_IDLE: enter_resp_s = req_valid && (LAT_LOAD == 4'd0);
      ST_WAIT: enter_resp_s = (cnt_r <= 4'd1);
      default: enter_resp_s = FALSE;
    endcase
  end

  assign error_s     = misalign_s | illegal_s | oor_s;
  assign commit_s    = enter_resp_s & acc_write_s & ~error_s;
  assign load_data_s = (error_s || acc_write_s) ? 32'h0000_0000 : rdata_ext_s;

  // Transaction FSM: accept, count down the latency, hold the response until taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      hold_write_r  <= FALSE;
      hold_funct3_r <= 3'b000;
      hold_addr_r   <= 32'h0000_0000;
      hold_wdata_r  <= 32'h0000_0000;
      req_ready_r   <= TRUE;
      rsp_valid_r   <= FALSE;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_error_r   <= FALSE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            hold_write_r  <= req_write;
            hold_funct3_r <= req_funct3;
            hold_addr_r   <= req_addr;
            hold_wdata_r  <= req_wdata;
            req_ready_r   <= FALSE;
            if (enter_resp_s) begin
              state_r     <= ST_RESP;
              cnt_r       <= 4'd0;
              rsp_valid_r <= TRUE;
              rsp_rdata_r <= load_data_s;
              rsp_error_r <= error_s;
            end else begin
              state_r     <= ST_WAIT;
              cnt_r       <= LAT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (enter_resp_s) begin
            state_r     <= ST_RESP;
            cnt_r       <= 4'd0;
            rsp_valid_r <= TRUE;
            rsp_rdata_r <= load_data_s;
            rsp_error_r <= error_s;
          end else begin
            cnt_r       <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= FALSE;
            req_ready_r <= TRUE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          rsp_valid_r <= FALSE;
          req_ready_r <= TRUE;
        end
      endcase
    end
  end

  // Byte-array store port; reset suppresses the commit but never clears contents
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // contents are deliberately retained across reset
    end else if (commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[{word_idx_s, 2'(i)}] <= wdata_shifted_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;
  assign dbg_byte  = mem_r[dbg_addr];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 4, 1) driven by
// directed scenarios and random traffic, checked against a byte-array model.
module tb_dmem_responder;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  reset, req_valid, rsp_ready, req_ready, rsp_valid, rsp_error;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [5:0]  dbg_addr;
  logic [31:0] rsp_rdata [3];
  logic [7:0]  dbg_byte [3];

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] refm [3][64];

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0]), .dbg_addr(dbg_addr), .dbg_byte(dbg_byte[0]));

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1]), .dbg_addr(dbg_addr), .dbg_byte(dbg_byte[1]));

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_error(rsp_error[2]), .dbg_addr(dbg_addr), .dbg_byte(dbg_byte[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int fsize(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    else if (f3[1:0] == 2'd1) return 2;
    else return 4;
  endfunction

  // Reference legality: width code, natural alignment, backed range
  function automatic bit exp_err(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (wr && (f3 == F_BU || f3 == F_HU)) return 1'b1;
    if ((a % fsize(f3)) != 0) return 1'b1;
    if (a >= 32'd64) return 1'b1;
    return 1'b0;
  endfunction

  // Reference load: little-endian sum of bytes, two's-complement for signed widths
  function automatic logic [31:0] exp_load(input int k, input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    int n = fsize(f3);
    for (int i = 0; i < n; i++) v = v + (longint'(refm[k][int'(a[5:0]) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
    return 32'(v);
  endfunction

  task automatic txn(input int k, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic err, output int lat);
    int n = 0;
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid[k] = 1'b1; rsp_ready[k] = 1'b0;
    while (req_ready[k] !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    check("req_ready_before_accept", {31'd0, req_ready[k]}, 32'd1);
    @(posedge clock); #1;
    req_valid[k] = 1'b0;
    lat = 1;
    while (rsp_valid[k] !== 1'b1 && lat < 40) begin @(posedge clock); #1; lat++; end
    rd = rsp_rdata[k]; err = rsp_error[k];
    rsp_ready[k] = 1'b1; @(posedge clock); #1; rsp_ready[k] = 1'b0;
  endtask

  task automatic run(input int k, input int lat_exp, input string tag, input bit wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, x;
    logic err;
    int lat;
    bit e;
    e = exp_err(wr, f3, a);
    x = (e || wr) ? 32'h0 : exp_load(k, f3, a);
    txn(k, wr, f3, a, wd, rd, err, lat);
    check({tag, ".latency"}, lat, lat_exp);
    check({tag, ".error"}, {31'd0, err}, {31'd0, e});
    check({tag, ".rdata"}, rd, x);
    if (wr && !e) for (int i = 0; i < fsize(f3); i++) refm[k][int'(a[5:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic chk_mem(input int k, input int lo, input int hi, input string tag);
    for (int a = lo; a <= hi; a++) begin
      dbg_addr = 6'(a); #1;
      check(tag, {24'd0, dbg_byte[k]}, {24'd0, refm[k][a]});
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [7:0]  t1_bytes [4];
    logic [31:0] held;
    logic [2:0]  legal [5];
    t1_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    legal = '{F_B, F_H, F_W, F_BU, F_HU};
    reset = 3'b111; req_valid = 3'b000; rsp_ready = 3'b000;
    req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; dbg_addr = 6'd0;
    repeat (2) @(posedge clock); #1;
    reset = 3'b000; #1;
    for (int k = 0; k < 3; k++) begin
      check("reset.rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      check("reset.rsp_error", {31'd0, rsp_error[k]}, 32'd0);
      check("reset.rsp_rdata", rsp_rdata[k], 32'd0);
      check("reset.req_ready", {31'd0, req_ready[k]}, 32'd1);
    end
    @(posedge clock); #1;

    // Fill the latency-2 instance so every byte has a known value
    for (int w = 0; w < 16; w++) run(0, 2, "init", 1'b1, F_W, 32'(w * 4), $urandom);

    // Test 1: SW 0x08
    run(0, 2, "t1.sw", 1'b1, F_W, 32'h08, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 6'(8 + i); #1;
      check("t1.dbg_byte", {24'd0, dbg_byte[0]}, {24'd0, t1_bytes[i]});
    end
    @(posedge clock); #1;

    // Test 2: loads with extension
    run(0, 2, "t2.lb",  1'b0, F_B,  32'h0B, 32'h0);
    run(0, 2, "t2.lbu", 1'b0, F_BU, 32'h0B, 32'h0);
    run(0, 2, "t2.lh",  1'b0, F_H,  32'h0A, 32'h0);
    run(0, 2, "t2.lhu", 1'b0, F_HU, 32'h0A, 32'h0);
    run(0, 2, "t2.lw",  1'b0, F_W,  32'h08, 32'h0);
    check("t2.model_lb", exp_load(0, F_B, 32'h0B), 32'hFFFFFFDE);
    check("t2.model_lh", exp_load(0, F_H, 32'h0A), 32'hFFFFDEAD);

    // Test 3: error cases
    run(0, 2, "t3.lw_mis", 1'b0, F_W,  32'h06, 32'h0);
    run(0, 2, "t3.sh_mis", 1'b1, F_H,  32'h09, 32'h11223344);
    chk_mem(0, 8, 11, "t3.sh_mis_mem");
    run(0, 2, "t3.lw_oor", 1'b0, F_W,  32'h40, 32'h0);
    run(0, 2, "t3.sbu",    1'b1, F_BU, 32'h0C, 32'h55667788);
    chk_mem(0, 12, 15, "t3.sbu_mem");

    // Test 4: response backpressure with an ignored request pulse
    req_write = 1'b0; req_funct3 = F_W; req_addr = 32'h08; req_wdata = 32'h0;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    @(posedge clock); #1;
    check("t4.rsp_valid_rise", {31'd0, rsp_valid[0]}, 32'd1);
    held = exp_load(0, F_W, 32'h08);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_write = 1'b1; req_funct3 = F_W; req_addr = 32'h08; req_wdata = 32'h0BADF00D;
        req_valid[0] = 1'b1;
      end else begin
        req_valid[0] = 1'b0;
      end
      @(posedge clock); #1;
      check("t4.hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("t4.hold_rdata", rsp_rdata[0], held);
      check("t4.hold_error", {31'd0, rsp_error[0]}, 32'd0);
      check("t4.req_ready_low", {31'd0, req_ready[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clock); #1;
    rsp_ready[0] = 1'b0;
    check("t4.release_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("t4.release_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clock); #1;
    check("t4.no_ghost_rsp", {31'd0, rsp_valid[0]}, 32'd0);
    chk_mem(0, 8, 11, "t4.mem_unchanged");

    // Test 5: reset during WAIT drops the pending store
    run(1, 4, "t5.pre", 1'b1, F_W, 32'h00, 32'hCAFEF00D);
    req_write = 1'b1; req_funct3 = F_W; req_addr = 32'h00; req_wdata = 32'h12345678;
    req_valid[1] = 1'b1;
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    @(posedge clock); #1;
    reset[1] = 1'b1; #1;
    check("t5.async_valid", {31'd0, rsp_valid[1]}, 32'd0);
    @(posedge clock); #1;
    reset[1] = 1'b0; #1;
    check("t5.post_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("t5.post_ready", {31'd0, req_ready[1]}, 32'd1);
    repeat (5) @(posedge clock); #1;
    check("t5.no_late_rsp", {31'd0, rsp_valid[1]}, 32'd0);
    chk_mem(1, 0, 3, "t5.mem_kept");
    run(1, 4, "t5.lw", 1'b0, F_W, 32'h00, 32'h0);

    // Test 6: latency 1, rsp_ready tied high, back-to-back SB then LBU
    rsp_ready[2] = 1'b1;
    req_write = 1'b1; req_funct3 = F_B; req_addr = 32'h10; req_wdata = 32'h000000A5;
    req_valid[2] = 1'b1;
    @(posedge clock); #1;
    check("t6.sb_valid", {31'd0, rsp_valid[2]}, 32'd1);
    check("t6.sb_error", {31'd0, rsp_error[2]}, 32'd0);
    check("t6.sb_busy", {31'd0, req_ready[2]}, 32'd0);
    req_write = 1'b0; req_funct3 = F_BU;
    @(posedge clock); #1;
    check("t6.idle_valid", {31'd0, rsp_valid[2]}, 32'd0);
    check("t6.idle_ready", {31'd0, req_ready[2]}, 32'd1);
    @(posedge clock); #1;
    req_valid[2] = 1'b0;
    check("t6.lbu_valid", {31'd0, rsp_valid[2]}, 32'd1);
    check("t6.lbu_rdata", rsp_rdata[2], 32'h000000A5);
    check("t6.lbu_error", {31'd0, rsp_error[2]}, 32'd0);
    @(posedge clock); #1;
    check("t6.done", {31'd0, rsp_valid[2]}, 32'd0);
    rsp_ready[2] = 1'b0;

    // Random traffic on the fully initialised latency-2 instance
    for (int n = 0; n < 150; n++) begin
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = legal[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        a = (32'h1 << $urandom_range(6, 31)) | 32'($urandom_range(0, 63));
      end else begin
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a = a & ~(32'(fsize(f3)) - 32'd1);
      end
      run(0, 2, "rnd", wr, f3, a, $urandom);
    end
    chk_mem(0, 0, 63, "final_mem");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32I core. The core's MEM stage is the initiator; this block is the memory side that accepts load/store requests and returns responses.
- It owns a byte-addressed, little-endian data array. It performs RV32I byte/half/word loads with sign or zero extension and byte/half/word stores.
- Access latency is programmable. Request and response channels each use a valid/ready handshake.
- This replaces the core's internal single-cycle dmem array once the MEM stage gains stall support.

Parameters:
ADDR_WIDTH, 6, byte-address bits actually backed (depth = 2**ADDR_WIDTH bytes).
LATENCY, 1, cycles from request-accept edge to the edge that raises rsp_valid; legal range is 1..15.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_write  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data; low bytes are used for B/H.
rsp_valid  out  1  response present.
rsp_ready  in  1  initiator accepts response.
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
rsp_error  out  1  misaligned, out-of-range or illegal funct3.
dbg_addr  in  ADDR_WIDTH  bench peek address.
dbg_byte  out  8  combinational read of mem[dbg_addr].

Behaviour:
- Reset (async, effective immediately): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE. There is no overlap between transactions.
  - IDLE: when req_valid is high, capture req_* into holding registers and load the counter with LATENCY-1. Go to WAIT, or go directly to RESP if LATENCY==1.
  - WAIT: decrement the counter each cycle. On the edge where the counter reaches 0, perform the access and enter RESP.
  - Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
  - RESP: hold rsp_valid, rsp_rdata and rsp_error stable until rsp_ready=1. On that edge go to IDLE and clear rsp_valid.
  - Minimum throughput is one transaction per LATENCY+1 cycles.
- Access timing:
  - A load samples memory on the edge entering RESP.
  - A store commits its bytes on the same edge, so a following load sees the new data.
- Error conditions (any one sets rsp_error=1, rdata=0, no memory write):
  - Illegal funct3: 011, 110, 111; for stores, also 100 and 101.
  - Misaligned half: addr[0]!=0.
  - Misaligned word: addr[1:0]!=0.
  - Out of range: any of req_addr[31:ADDR_WIDTH] nonzero.
- Load extension:
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W returns mem[a+3..a] with byte a at bits 7:0.
- Store byte lanes: B writes wdata[7:0] to mem[a]; H writes 2 bytes; W writes 4 bytes, little-endian.
- Handshake rules:
  - req_* are ignored whenever req_ready=0.
  - rsp_ready is ignored when rsp_valid=0.
- Reset mid-operation: a pending transaction is dropped and an uncommitted store never commits.
- Reset asserted on the same edge as a commit: reset wins and no write occurs.

Decomposition:
- Shared package mem_defs:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding.
  - TRUE/FALSE defines, as used by the core.
- One combinational sub-module, mem_align. Inputs: funct3, addr low bits, write flag, wdata, raw read word. Outputs: byte-enable[3:0], shifted store data, extended load data, misalign/illegal flags.
- dmem_responder itself holds the FSM, counter, holding registers and byte array.

Test Plan:
1. Reset, LATENCY=2: SW addr 0x08 data 0xDEADBEEF. Expect rsp_valid exactly 2 cycles after accept, rsp_error=0, rsp_rdata=0. dbg_byte at 0x08..0x0B reads EF, BE, AD, DE.
2. After test 1:
   - LB 0x0B returns 0xFFFFFFDE; LBU 0x0B returns 0x000000DE.
   - LH 0x0A returns 0xFFFFDEAD; LHU 0x0A returns 0x0000DEAD.
   - LW 0x08 returns 0xDEADBEEF.
3. Error cases, each expecting rsp_error=1 and rdata=0:
   - LW 0x06.
   - SH 0x09, with bytes 0x08..0x0B unchanged.
   - LW 0x40 (out of range).
   - Store with funct3=100, with memory unchanged.
4. Response backpressure: hold rsp_ready=0 for 5 cycles during an LW response. rsp_valid, rsp_rdata and rsp_error stay stable and req_ready stays 0. A req_valid pulse during this window is not accepted. Then rsp_ready=1 returns the FSM to IDLE the next cycle.
5. Reset during WAIT (LATENCY=4) of SW 0x00 data 0x12345678. rsp_valid=0 and req_ready=1 immediately after reset deasserts. Bytes 0x00..0x03 keep their prior values.
6. LATENCY=1, rsp_ready tied to 1: SB 0x10 data 0x000000A5, then LBU 0x10. The load returns 0x000000A5. Transactions complete every 2 cycles.
